// File: rtl/datamem_responder_pkg.sv
// Shared encodings for the data-memory responder and the core control unit.
package datamem_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_COUNT   = 3'b001,
    ST_RESPOND = 3'b010,
    ST_HOLD    = 3'b011
  } dmr_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/datamem_responder_lane_unit.sv
// Byte-enable generation, store lane replication and load extension for one access.
module DMR_LANE_UNIT
  import datamem_responder_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_word,
  output logic [31:0] rd_data,
  output logic        fault
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = rd_word[{addr_lo, 3'b000} +: 8];
  assign rd_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    byte_en = '0;
    wr_word = '0;
    rd_data = '0;
    fault   = 1'b0;
    case (funct3)
      F3_B: begin
        byte_en = 4'b0001 << addr_lo;
        wr_word = {4{wr_data[7:0]}};
        rd_data = {{24{rd_byte[7]}}, rd_byte};
      end
      F3_BU: begin
        fault   = is_store;
        rd_data = {24'h0, rd_byte};
      end
      F3_H: begin
        fault   = addr_lo[0];
        byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wr_data[15:0]}};
        rd_data = {{16{rd_half[15]}}, rd_half};
      end
      F3_HU: begin
        fault   = is_store | addr_lo[0];
        rd_data = {16'h0, rd_half};
      end
      F3_W: begin
        fault   = |addr_lo;
        byte_en = 4'b1111;
        wr_word = wr_data;
        rd_data = rd_word;
      end
      default: fault = 1'b1;
    endcase
    // Store enables only matter for stores; faulted accesses neither write nor return data.
    if (fault || !is_store) byte_en = '0;
    if (fault || is_store)  rd_data = '0;
  end

endmodule

// File: rtl/datamem_responder.sv
// Single-port data memory responder with programmable wait latency and fault reporting.
module datamem_responder
  import datamem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        DMR_Clk,
  input  logic        DMR_Reset,
  input  logic        DMR_Ready_In,
  input  logic        DMR_Valid_In,
  input  logic [31:0] DMR_Addr_InBUS,
  input  logic [31:0] DMR_WrData_InBUS,
  input  logic [2:0]  DMR_Funct3_InBUS,
  output logic        DMR_Valid_Out,
  output logic        DMR_Ready_Out,
  output logic [31:0] DMR_RdData_OutBUS,
  output logic        DMR_Error_Out,
  output logic [2:0]  DMR_Internal_State
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  dmr_state_e  state;
  logic [3:0]  cnt;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  f3_q;
  logic        store_q, dual_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          oor, lane_fault, fault, do_write;
  logic [3:0]    byte_en;
  logic [31:0]   wr_word, rd_word, lane_rd;

  assign idx     = addr_q[AW+1:2];
  assign oor     = |addr_q[31:AW+2];
  assign rd_word = mem[idx];
  assign fault   = lane_fault | oor | dual_q;

  DMR_LANE_UNIT u_lane (
    .funct3  (f3_q),
    .addr_lo (addr_q[1:0]),
    .is_store(store_q),
    .wr_data (wdata_q),
    .rd_word (rd_word),
    .byte_en (byte_en),
    .wr_word (wr_word),
    .rd_data (lane_rd),
    .fault   (lane_fault)
  );

  // Reset gates the write so an aborted store never lands.
  assign do_write = (state == ST_RESPOND) && store_q && !fault && !DMR_Reset;

  always_ff @(posedge DMR_Clk) begin
    if (do_write)
      for (int b = 0; b < 4; b++)
        if (byte_en[b]) mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
  end

  always_ff @(posedge DMR_Clk) begin
    if (DMR_Reset) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      addr_q            <= '0;
      wdata_q           <= '0;
      f3_q              <= '0;
      store_q           <= 1'b0;
      dual_q            <= 1'b0;
      DMR_Valid_Out     <= 1'b0;
      DMR_Ready_Out     <= 1'b0;
      DMR_Error_Out     <= 1'b0;
      DMR_RdData_OutBUS <= '0;
    end else begin
      DMR_Valid_Out     <= 1'b0;
      DMR_Ready_Out     <= 1'b0;
      DMR_Error_Out     <= 1'b0;
      DMR_RdData_OutBUS <= '0;
      case (state)
        ST_IDLE: begin
          if (DMR_Ready_In || DMR_Valid_In) begin
            addr_q  <= DMR_Addr_InBUS;
            wdata_q <= DMR_WrData_InBUS;
            f3_q    <= DMR_Funct3_InBUS;
            // Simultaneous requests degrade to a faulted load.
            store_q <= DMR_Valid_In & ~DMR_Ready_In;
            dual_q  <= DMR_Valid_In & DMR_Ready_In;
            cnt     <= CNT_INIT;
            state   <= (LATENCY > 0) ? ST_COUNT : ST_RESPOND;
          end
        end
        ST_COUNT: begin
          if (cnt == 4'd0) state <= ST_RESPOND;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESPOND: begin
          DMR_Valid_Out     <= ~store_q;
          DMR_Ready_Out     <= store_q;
          DMR_Error_Out     <= fault;
          DMR_RdData_OutBUS <= (store_q || fault) ? 32'h0 : lane_rd;
          state             <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!DMR_Ready_In && !DMR_Valid_In) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign DMR_Internal_State = state;

endmodule

// File: doc/datamem_responder.md
DATAMEM_RESPONDER -- requirements
Module: DATAMEM_RESPONDER

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, SHALL set the number of 32-bit memory words (power of two, 16..4096).
REQ-002 Parameter LATENCY, default 2, SHALL set the wait cycles (0..15) inserted before each response.
REQ-003 DMR_Clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 DMR_Reset  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 DMR_Ready_In  input  1  SHALL be the load request, meaning the initiator is ready to receive read data.
REQ-006 DMR_Valid_In  input  1  SHALL be the store request, meaning the initiator's write data is valid.
REQ-007 DMR_Addr_InBUS  input  32  SHALL be the byte address.
REQ-008 DMR_WrData_InBUS  input  32  SHALL be the store data, right-aligned.
REQ-009 DMR_Funct3_InBUS  input  3  SHALL be the RV32I access size/sign code.
REQ-010 DMR_Valid_Out  output  1  SHALL be the one-cycle load-complete pulse.
REQ-011 DMR_Ready_Out  output  1  SHALL be the one-cycle store-complete pulse.
REQ-012 DMR_RdData_OutBUS  output  32  SHALL carry the extended load data, valid while DMR_Valid_Out=1.
REQ-013 DMR_Error_Out  output  1  SHALL flag a faulted access, valid with the completion pulse.
REQ-014 DMR_Internal_State  output  3  SHALL expose the state register.

Function
REQ-015 States SHALL be IDLE=000, COUNT=001, RESPOND=010, HOLD=011; other encodings SHALL go to IDLE.
REQ-016 IDLE SHALL sample requests; when either request is 1, it SHALL latch address, write data, funct3 and request type, then go to COUNT if LATENCY>0, else RESPOND.
REQ-017 When both requests are 1 in IDLE, the block SHALL treat the access as a load with error set.
REQ-018 COUNT SHALL decrement a 4-bit counter preloaded with LATENCY-1 and SHALL go to RESPOND after reaching 0, so the completion pulse lands exactly LATENCY+1 cycles after the request was sampled.
REQ-019 RESPOND SHALL last one cycle and assert DMR_Valid_Out (load) or DMR_Ready_Out (store); all outputs SHALL be registered or decoded from state only, with no input-to-output paths.
REQ-020 HOLD SHALL wait until both requests are 0, then return to IDLE, so that one request never yields two pulses.
REQ-021 The word index SHALL be Addr[log2(DEPTH_WORDS)+1:2].
REQ-022 An address >= 4*DEPTH_WORDS SHALL be out of range.
REQ-023 Loads SHALL support funct3 000 LB and 100 LBU (byte lane Addr[1:0]), and 001 LH and 101 LHU (half lane Addr[1]), sign- or zero-extended; 010 LW SHALL return the full word.
REQ-024 Stores SHALL support 000 SB, 001 SH and 010 SW, writing only the selected byte lanes in the RESPOND cycle.
REQ-025 Misaligned accesses (half with Addr[0]=1; word with Addr[1:0]!=0), out-of-range addresses and illegal funct3 (loads 011/110/111; stores other than 000/001/010) SHALL assert DMR_Error_Out with the pulse, suppress the write, and return read data 0.
REQ-026 DMR_RdData_OutBUS SHALL be 0 whenever DMR_Valid_Out=0.

Reset
REQ-027 DMR_Reset=1 SHALL force IDLE, counter 0, and DMR_Valid_Out, DMR_Ready_Out, DMR_Error_Out and DMR_RdData_OutBUS to 0 on the next edge, including in the middle of a transaction.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 An aborted store SHALL NOT write memory.

Structure
REQ-030 The state encodings and funct3 codes SHALL live in a shared package, also used by the core control unit.
REQ-031 One sub-module, DMR_LANE_UNIT, SHALL hold the combinational byte-enable, store-alignment and load-extension logic.
REQ-032 The memory array SHALL be a plain registered array in the top module.

Verification
REQ-033 Store SW, addr 0x10, data 0xDEADBEEF, LATENCY=2: the bench SHALL see DMR_Ready_Out pulse at cycle 3 and error 0, and a later LW at 0x10 SHALL return 0xDEADBEEF.
REQ-034 SB 0x80 to addr 0x11, then LB 0x11 and LBU 0x11: the loads SHALL return 0xFFFFFF80 and 0x00000080, and LW 0x10 SHALL return 0xDEAD80EF.
REQ-035 LH at addr 0x13: the bench SHALL see the pulse with DMR_Error_Out=1 and data 0; SW at 0x400 with DEPTH_WORDS=256 SHALL give error 1 with memory unchanged.
REQ-036 With LATENCY=0 and DMR_Ready_In held high for 5 cycles, the bench SHALL see exactly one DMR_Valid_Out pulse, at cycle 1, with the state in HOLD until the request drops.
REQ-037 DMR_Reset asserted during COUNT of an SW: the bench SHALL see the state return to IDLE, no pulse, and the target word unchanged.
REQ-038 Both requests high in IDLE: the bench SHALL see a DMR_Valid_Out pulse with error 1 and no write.
